// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson (twisted-ring) code consumers.
// Helpers take a zero-extended word plus its real width so any WIDTH up to JC_MAX_W can share them.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2,
    JUMP = 2'd3
  } step_e;

  localparam int unsigned JC_MAX_W = 32;

  // A Johnson word has at most one boundary between its run of ones and its run of zeros.
  function automatic logic jc_legal(input logic [JC_MAX_W-1:0] word,
                                    input int unsigned          width);
    int unsigned edges;
    edges = 0;
    for (int unsigned i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i + 1 < width) && (word[i] != word[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic int unsigned jc_to_idx(input logic [JC_MAX_W-1:0] word,
                                            input int unsigned          width);
    int unsigned ones;
    logic        msb;
    ones = 0;
    msb  = 1'b0;
    for (int unsigned i = 0; i < JC_MAX_W; i++) begin
      if (i < width && word[i]) ones++;
      if (i == width - 1)       msb = word[i];
    end
    if (msb) return (2 * width - ones) % (2 * width);
    return ones;
  endfunction

endpackage

// File: rtl/johnson_decoder_word_check.sv
// Combinational legality check and index decode of one WIDTH-bit Johnson word.
// Module name johnson_word_check; reusable by any Johnson consumer.
module johnson_word_check
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_jc,
  output logic             o_legal,
  output logic [IDX_W-1:0] o_idx
);

  logic [JC_MAX_W-1:0] w_word;

  assign w_word  = JC_MAX_W'(i_jc);
  assign o_legal = jc_legal(w_word, WIDTH);
  assign o_idx   = IDX_W'(jc_to_idx(w_word, WIDTH));

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code receiver: decode, legality flag, sequence-lock tracker and saturating error counter.
// Build option: define JOHNSON_DEC_BIDIR_EN to accept backward steps and report direction on dir.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int ERR_CNT_W = 8,
  localparam int IDX_W     = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     jc_in,
  output logic [IDX_W-1:0]     idx_out,
  output logic                 idx_valid,
  output logic                 illegal,
  output logic                 seq_err,
  output logic                 locked,
  output logic                 dir,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(2 * WIDTH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  logic                 w_legal;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_idx_fwd;
  logic [IDX_W-1:0]     w_idx_bwd;
  step_e                w_step;
  logic                 w_in_seq;
  logic                 w_take_legal;
  logic                 w_take_illegal;
  state_e               w_state_nxt;
  logic                 w_seq_err_nxt;
  logic                 w_dir_nxt;

  state_e               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_idx_valid;
  logic                 r_illegal;
  logic                 r_seq_err;
  logic                 r_dir;
  logic [ERR_CNT_W-1:0] r_err_count;

  johnson_word_check #(.WIDTH(WIDTH)) u_word_check (
    .i_jc    (jc_in),
    .o_legal (w_legal),
    .o_idx   (w_idx)
  );

  assign w_take_legal   = in_valid &  w_legal;
  assign w_take_illegal = in_valid & ~w_legal;

  // Neighbours of the previous index on the 2*WIDTH ring, so the wrap counts as a single step.
  always_comb begin
    w_idx_fwd = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_ONE;
    w_idx_bwd = (r_idx == '0) ? IDX_LAST : r_idx - IDX_ONE;
    if (w_idx == r_idx)          w_step = HOLD;
    else if (w_idx == w_idx_fwd) w_step = FWD;
    else if (w_idx == w_idx_bwd) w_step = BWD;
    else                         w_step = JUMP;
  end

`ifdef JOHNSON_DEC_BIDIR_EN
  assign w_in_seq = (w_step == FWD) || (w_step == BWD);
`else
  assign w_in_seq = (w_step == FWD);
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_seq_err_nxt = 1'b0;
    w_dir_nxt     = r_dir;

    if (w_take_illegal) begin
      w_state_nxt = UNLOCKED;
    end else if (w_take_legal) begin
      unique case (r_state)
        UNLOCKED: w_state_nxt = ARMED;
        ARMED: begin
          if (w_in_seq) w_state_nxt = LOCKED;
        end
        LOCKED: begin
          if (!w_in_seq && (w_step != HOLD)) begin
            w_seq_err_nxt = 1'b1;
            w_state_nxt   = ARMED;
          end
        end
        default: w_state_nxt = UNLOCKED;
      endcase
    end

`ifdef JOHNSON_DEC_BIDIR_EN
    if (w_take_legal && (r_state != UNLOCKED)) begin
      if (w_step == FWD)      w_dir_nxt = 1'b0;
      else if (w_step == BWD) w_dir_nxt = 1'b1;
    end
`else
    w_dir_nxt = 1'b0;
`endif
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= UNLOCKED;
      r_idx       <= '0;
      r_idx_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_dir       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx_valid <= w_take_legal;
      r_illegal   <= w_take_illegal;
      r_seq_err   <= w_seq_err_nxt;
      r_dir       <= w_dir_nxt;
      if (w_take_legal) r_idx <= w_idx;
      if ((w_take_illegal || w_seq_err_nxt) && (r_err_count != '1))
        r_err_count <= r_err_count + ERR_ONE;
    end
  end

  assign idx_out   = r_idx;
  assign idx_valid = r_idx_valid;
  assign illegal   = r_illegal;
  assign seq_err   = r_seq_err;
  assign locked    = (r_state == LOCKED);
  assign dir       = r_dir;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (WIDTH=4, ERR_CNT_W=8); honours JOHNSON_DEC_BIDIR_EN.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int E  = 8;
  localparam int N  = 2 * W;
  localparam int IW = $clog2(N);
  localparam int ERR_MAX = (1 << E) - 1;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  jc_in = '0;
  logic [IW-1:0] idx_out;
  logic          idx_valid, illegal, seq_err, locked, dir;
  logic [E-1:0]  err_count;

  johnson_decoder #(.WIDTH(W), .ERR_CNT_W(E)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .jc_in     (jc_in),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .locked    (locked),
    .dir       (dir),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference sequence of a twisted-ring counter: fill with ones from the LSB, then drain from the LSB.
  logic [W-1:0] tbl [N];

  bit m_ref, m_locked, m_dir, m_idx_valid, m_illegal, m_seq_err;
  int m_idx, m_err;
  bit bidir;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lookup(input logic [W-1:0] w);
    for (int k = 0; k < N; k++) if (tbl[k] == w) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_ref = 0; m_locked = 0; m_dir = 0; m_idx = 0; m_err = 0;
    m_idx_valid = 0; m_illegal = 0; m_seq_err = 0;
  endtask

  task automatic bump_err();
    if (m_err < ERR_MAX) m_err++;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] w);
    int k, d;
    m_idx_valid = 0; m_illegal = 0; m_seq_err = 0;
    if (!v) return;
    k = lookup(w);
    if (k < 0) begin
      m_illegal = 1; m_ref = 0; m_locked = 0;
      bump_err();
      return;
    end
    m_idx_valid = 1;
    if (!m_ref) begin
      m_ref = 1;
    end else begin
      d = (k - m_idx + N) % N;
      if (d == 1 || (bidir && d == N - 1)) begin
        m_locked = 1;
        if (bidir) m_dir = (d == N - 1);
      end else if (d != 0 && m_locked) begin
        m_seq_err = 1; m_locked = 0;
        bump_err();
      end
    end
    m_idx = k;
  endtask

  task automatic compare_all();
    check("idx_out",   32'(idx_out),   32'(m_idx));
    check("idx_valid", 32'(idx_valid), 32'(m_idx_valid));
    check("illegal",   32'(illegal),   32'(m_illegal));
    check("seq_err",   32'(seq_err),   32'(m_seq_err));
    check("locked",    32'(locked),    32'(m_locked));
    check("dir",       32'(dir),       32'(m_dir));
    check("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] w);
    @(negedge clk);
    in_valid = v;
    jc_in    = w;
    @(posedge clk);
    model_step(v, w);
    #1;
    compare_all();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
`ifdef JOHNSON_DEC_BIDIR_EN
    bidir = 1;
`else
    bidir = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (k <= W) tbl[k] = W'((1 << k) - 1);
      else        tbl[k] = W'(((1 << W) - 1) & ~((1 << (k - W)) - 1));
    end
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    clr = 1'b0;

    // Pin the reference table against hand-decoded words.
    check("tbl_5", 32'(lookup(4'b1110)), 32'd5);
    check("tbl_7", 32'(lookup(4'b1000)), 32'd7);
    check("tbl_0101_illegal", 32'(lookup(4'b0101)), 32'hFFFF_FFFF);

    // Full forward sweep with wrap back to zero.
    for (int k = 0; k <= N; k++) begin
      cycle(1'b1, tbl[k % N]);
      check("sweep_idx",    32'(idx_out), 32'(k % N));
      check("sweep_locked", 32'(locked),  32'(k >= 1));
    end
    cycle(1'b1, 4'b0000);
    check("hold_locked", 32'(locked), 32'd1);

    // Asynchronous clear while locked.
    pulse_clr();
    check("clr_locked", 32'(locked),    32'd0);
    check("clr_err",    32'(err_count), 32'd0);
    check("clr_idx",    32'(idx_out),   32'd0);

    // Illegal word while locked at idx 1.
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0001);
    cycle(1'b1, 4'b0101);
    check("ill_pulse",  32'(illegal),   32'd1);
    check("ill_idx",    32'(idx_out),   32'd1);
    check("ill_locked", 32'(locked),    32'd0);
    check("ill_err",    32'(err_count), 32'd1);
    cycle(1'b0, 4'b0101);
    check("ill_gap",    32'(illegal),   32'd0);

    // Jump while locked at idx 2.
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0001);
    cycle(1'b1, 4'b0011);
    cycle(1'b1, 4'b1110);
    check("jmp_seq_err", 32'(seq_err),   32'd1);
    check("jmp_idx",     32'(idx_out),   32'd5);
    check("jmp_locked",  32'(locked),    32'd0);
    check("jmp_err",     32'(err_count), 32'd2);

    // Re-arm by jump (no seq_err from ARMED), lock at 3, then step backward.
    cycle(1'b1, 4'b0011);
    check("rearm_seq_err", 32'(seq_err), 32'd0);
    cycle(1'b1, 4'b0111);
    check("relock", 32'(locked), 32'd1);
    cycle(1'b1, 4'b0011);
`ifdef JOHNSON_DEC_BIDIR_EN
    check("bwd_locked", 32'(locked),    32'd1);
    check("bwd_dir",    32'(dir),       32'd1);
    check("bwd_err",    32'(err_count), 32'd2);
    cycle(1'b1, 4'b0111);
    check("fwd_dir",    32'(dir),       32'd0);
`else
    check("bwd_seq_err", 32'(seq_err),   32'd1);
    check("bwd_dir",     32'(dir),       32'd0);
    check("bwd_err",     32'(err_count), 32'd3);
`endif

    // Saturation: 300 alternating illegal words with idle gaps.
    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 9) cycle(1'b0, 4'b0101);
      cycle(1'b1, (i % 2 == 0) ? 4'b0101 : 4'b1010);
    end
    check("sat_err", 32'(err_count), 32'd255);
    cycle(1'b0, 4'b1010);
    check("sat_gap_illegal", 32'(illegal),   32'd0);
    check("sat_hold",        32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
